// File: rtl/mux_arb.sv
// Registered N-channel round-robin arbitrating multiplexer with valid/ready on every port.
// Optional packet mode keeps the grant on one channel until its last beat has transferred.
module mux_arb #(
    parameter int N      = 4,
    parameter int W      = 32,
    parameter bit PACKET = 1'b0
) (
    input  logic                clk,
    input  logic                arst_n,
    input  logic [N-1:0]        i_x_vld,
    input  logic [N-1:0][W-1:0] i_x,
    input  logic [N-1:0]        i_x_last,
    output logic [N-1:0]        o_x_rdy,
    output logic                o_y_vld,
    output logic [W-1:0]        o_y,
    output logic                o_y_last,
    output logic [N-1:0]        o_y_sel,
    input  logic                i_y_rdy,
    output logic                o_dbg_locked
);

    // Handshake: a beat moves on any port when vld and rdy are both high at a rising edge.
    // Producers must not make vld depend on rdy; o_x_rdy may depend on i_x_vld and i_y_rdy.

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } lock_state_e;

    localparam logic [N-1:0] PTR_RST = N'(1);

    lock_state_e    state_q, state_d;
    logic [N-1:0]   ptr_q, ptr_d;
    logic [N-1:0]   owner_q, owner_d;
    logic           y_vld_q, y_vld_d;
    logic [W-1:0]   y_q, y_d;
    logic           y_last_q, y_last_d;
    logic [N-1:0]   y_sel_q, y_sel_d;

    logic [N-1:0]   rr_gnt;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ptr_rot;
    logic           found;
    logic           accept;
    logic           xfer;
    logic [W-1:0]   sel_x;
    logic           sel_last;

    // Cyclic first-set search starting at the one-hot pointer position.
    always_comb begin
        rr_gnt = '0;
        found  = 1'b0;
        for (int off = 0; off < N; off++) begin
            for (int k = 0; k < N; k++) begin
                if (!found && ptr_q[k] && i_x_vld[(k + off) % N]) begin
                    rr_gnt[(k + off) % N] = 1'b1;
                    found                 = 1'b1;
                end
            end
        end
    end

    always_comb begin
        gnt = rr_gnt;
        if (state_q == ST_LOCKED) begin
            gnt = owner_q & i_x_vld;
        end
    end

    assign accept  = !y_vld_q || i_y_rdy;
    assign o_x_rdy = gnt & {N{accept && arst_n}};
    assign xfer    = |o_x_rdy;

    always_comb begin
        sel_x    = '0;
        sel_last = 1'b0;
        ptr_rot  = '0;
        for (int k = 0; k < N; k++) begin
            if (gnt[k]) begin
                sel_x    = sel_x | i_x[k];
                sel_last = sel_last | i_x_last[k];
            end
            ptr_rot[(k + 1) % N] = gnt[k];
        end
    end

    always_comb begin
        y_vld_d  = y_vld_q;
        y_d      = y_q;
        y_last_d = y_last_q;
        y_sel_d  = y_sel_q;
        ptr_d    = ptr_q;
        state_d  = state_q;
        owner_d  = owner_q;

        if (xfer) begin
            y_vld_d  = 1'b1;
            y_d      = sel_x;
            y_last_d = PACKET ? sel_last : 1'b0;
            y_sel_d  = gnt;
        end else if (i_y_rdy) begin
            y_vld_d  = 1'b0;
        end

        // In packet mode the pointer only advances at packet boundaries.
        if (xfer && (!PACKET || sel_last)) begin
            ptr_d = ptr_rot;
        end

        if (PACKET && xfer) begin
            if (sel_last) begin
                state_d = ST_OPEN;
            end else begin
                state_d = ST_LOCKED;
                owner_d = gnt;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= ST_OPEN;
            ptr_q    <= PTR_RST;
            owner_q  <= '0;
            y_vld_q  <= 1'b0;
            y_q      <= '0;
            y_last_q <= 1'b0;
            y_sel_q  <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            y_vld_q  <= y_vld_d;
            y_q      <= y_d;
            y_last_q <= y_last_d;
            y_sel_q  <= y_sel_d;
        end
    end

    assign o_y_vld      = y_vld_q;
    assign o_y          = y_q;
    assign o_y_last     = y_last_q;
    assign o_y_sel      = y_sel_q;
    assign o_dbg_locked = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_mux_arb.sv
// Directed bench for mux_arb: one instance per-beat arbitration, one in packet mode,
// output beats checked against an expected-beat queue.
module tb_mux_arb;

    logic                clk;
    logic                arst_n;

    logic [3:0]          a_vld, a_last, a_x_rdy, a_y_sel;
    logic [3:0][7:0]     a_x;
    logic                a_y_vld, a_y_last, a_y_rdy, a_dbg;
    logic [7:0]          a_y;

    logic [3:0]          b_vld, b_last, b_x_rdy, b_y_sel;
    logic [3:0][7:0]     b_x;
    logic                b_y_vld, b_y_last, b_y_rdy, b_dbg;
    logic [7:0]          b_y;

    logic [12:0]         exp_q[$];
    int                  n_checks;
    int                  n_errors;
    logic [3:0]          oh;

    mux_arb #(.N(4), .W(8), .PACKET(1'b0)) u_rr (
        .clk(clk), .arst_n(arst_n),
        .i_x_vld(a_vld), .i_x(a_x), .i_x_last(a_last), .o_x_rdy(a_x_rdy),
        .o_y_vld(a_y_vld), .o_y(a_y), .o_y_last(a_y_last), .o_y_sel(a_y_sel),
        .i_y_rdy(a_y_rdy), .o_dbg_locked(a_dbg)
    );

    mux_arb #(.N(4), .W(8), .PACKET(1'b1)) u_pk (
        .clk(clk), .arst_n(arst_n),
        .i_x_vld(b_vld), .i_x(b_x), .i_x_last(b_last), .o_x_rdy(b_x_rdy),
        .o_y_vld(b_y_vld), .o_y(b_y), .o_y_last(b_y_last), .o_y_sel(b_y_sel),
        .i_y_rdy(b_y_rdy), .o_dbg_locked(b_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [12:0] beat(input logic l, input logic [3:0] s, input logic [7:0] d);
        return {l, s, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [12:0] obs);
        n_checks++;
        assert (exp_q.size() != 0) else begin
            n_errors++;
            $error("FAIL %s: observed beat %0h expected none", tag, obs);
        end
        if (exp_q.size() != 0) chk(tag, {19'd0, obs}, {19'd0, exp_q.pop_front()});
    endtask

    task tick_a();
        if (a_y_vld && a_y_rdy) sb_pop("rr_beat", {a_y_last, a_y_sel, a_y});
        @(posedge clk);
        #2;
    endtask

    task tick_b();
        if (b_y_vld && b_y_rdy) sb_pop("pk_beat", {b_y_last, b_y_sel, b_y});
        @(posedge clk);
        #2;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        arst_n   = 1'b0;
        a_vld    = 4'hF;
        a_last   = 4'hF;
        a_y_rdy  = 1'b1;
        b_vld    = 4'hF;
        b_last   = 4'hF;
        b_y_rdy  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a_x[k] = 8'(8'hA0 + k);
            b_x[k] = 8'(8'hB0 + k);
        end

        // Reset held with every channel requesting.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_a_vld", a_y_vld, 0);
        chk("rst_a_y", a_y, 0);
        chk("rst_a_sel", a_y_sel, 0);
        chk("rst_a_rdy", a_x_rdy, 0);
        chk("rst_a_last", a_y_last, 0);
        chk("rst_b_vld", b_y_vld, 0);
        chk("rst_b_rdy", b_x_rdy, 0);
        chk("rst_b_lock", b_dbg, 0);

        arst_n = 1'b1;
        b_vld  = 4'h0;
        #1;

        // Round robin with all channels valid.
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            chk("rr_rdy", a_x_rdy, oh);
            exp_q.push_back(beat(1'b0, oh, 8'(8'hA0 + (k % 4))));
            tick_a();
        end
        chk("rr_last_zero", a_y_last, 0);

        // Back-pressure on a pending channel-2 beat.
        a_vld  = 4'b0100;
        a_x[2] = 8'h55;
        #1;
        chk("bp_load_rdy", a_x_rdy, 4'b0100);
        exp_q.push_back(beat(1'b0, 4'b0100, 8'h55));
        tick_a();
        a_vld   = 4'b1011;
        a_x[2]  = 8'hA2;
        a_y_rdy = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_rdy", a_x_rdy, 0);
            chk("bp_hold", a_y, 8'h55);
            chk("bp_vld", a_y_vld, 1);
            chk("bp_sel", a_y_sel, 4'b0100);
            tick_a();
        end
        a_y_rdy = 1'b1;
        #1;
        chk("bp_release_rdy", a_x_rdy, 4'b1000);
        exp_q.push_back(beat(1'b0, 4'b1000, 8'hA3));
        tick_a();
        chk("no_bubble", a_y_vld, 1);

        // Only channels 1 and 3 requesting, pointer at 0.
        a_vld = 4'b1010;
        #1;
        for (int i = 0; i < 4; i++) begin
            oh = (i % 2 == 1) ? 4'b1000 : 4'b0010;
            chk("skip_rdy", a_x_rdy, oh);
            exp_q.push_back(beat(1'b0, oh, (i % 2 == 1) ? 8'hA3 : 8'hA1));
            tick_a();
        end
        a_vld = 4'b1011;
        #1;
        chk("skip_ch0", a_x_rdy, 4'b0001);
        exp_q.push_back(beat(1'b0, 4'b0001, 8'hA0));
        tick_a();
        a_vld = 4'b0000;
        #1;
        chk("idle_rdy", a_x_rdy, 0);
        tick_a();
        chk("drain_vld", a_y_vld, 0);
        chk("rr_q_empty", exp_q.size(), 0);

        // Packet mode: single-beat packet from channel 0 moves the pointer to 1.
        b_vld  = 4'b0001;
        b_x[0] = 8'hC0;
        b_last = 4'b0001;
        #1;
        chk("pk_first", b_x_rdy, 4'b0001);
        exp_q.push_back(beat(1'b1, 4'b0001, 8'hC0));
        tick_b();

        b_vld  = 4'b0011;
        b_x[1] = 8'hD1;
        #1;
        chk("pk_beat1", b_x_rdy, 4'b0010);
        exp_q.push_back(beat(1'b0, 4'b0010, 8'hD1));
        tick_b();
        chk("pk_locked", b_dbg, 1);

        b_vld = 4'b0001;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("pk_gap", b_x_rdy, 0);
            tick_b();
        end

        b_vld  = 4'b0011;
        b_x[1] = 8'hD2;
        #1;
        chk("pk_beat2", b_x_rdy, 4'b0010);
        exp_q.push_back(beat(1'b0, 4'b0010, 8'hD2));
        tick_b();

        b_x[1] = 8'hD3;
        b_last = 4'b0011;
        #1;
        chk("pk_beat3", b_x_rdy, 4'b0010);
        exp_q.push_back(beat(1'b1, 4'b0010, 8'hD3));
        tick_b();
        chk("pk_unlocked", b_dbg, 0);
        chk("pk_last_out", b_y_last, 1);

        b_vld = 4'b0001;
        #1;
        chk("pk_after", b_x_rdy, 4'b0001);
        exp_q.push_back(beat(1'b1, 4'b0001, 8'hC0));
        tick_b();

        // Reset while locked to channel 3 with a beat pending.
        b_vld  = 4'b1001;
        b_x[3] = 8'hE1;
        b_last = 4'b0001;
        #1;
        chk("mr_grant3", b_x_rdy, 4'b1000);
        exp_q.push_back(beat(1'b0, 4'b1000, 8'hE1));
        tick_b();
        chk("mr_locked", b_dbg, 1);
        chk("mr_pending", b_y_vld, 1);

        arst_n = 1'b0;
        #1;
        chk("mr_vld", b_y_vld, 0);
        chk("mr_y", b_y, 0);
        chk("mr_sel", b_y_sel, 0);
        chk("mr_rdy", b_x_rdy, 0);
        chk("mr_lock", b_dbg, 0);
        exp_q.delete();
        @(posedge clk);
        #2;
        arst_n = 1'b1;
        #1;
        chk("mr_first", b_x_rdy, 4'b0001);
        exp_q.push_back(beat(1'b1, 4'b0001, 8'hC0));
        tick_b();
        b_vld = 4'b0000;
        #1;
        tick_b();
        chk("pk_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mux_arb.md
# mux_arb

Registered N-channel arbitrating multiplexer with valid/ready handshakes on every input and on the output. Each cycle it selects one requesting channel by round-robin priority and forwards that channel's W-bit beat through a single output register. In packet mode it holds the grant until the selected channel's last beat has transferred. It replaces a bare one-hot AND-OR select wherever sources are independent producers that need fair, back-pressured access to a shared sink.

## Interface

- N, 4, number of input channels (N >= 1)
- W, 32, beat width in bits
- PACKET, 0, 1 = grant locks to a channel until a beat with last set transfers; 0 = arbitrate every beat
- clk  in  1  clock; all state on rising edge
- arst_n  in  1  reset, asynchronous assert, active-low
- i_x_vld  in  N  per-channel beat valid
- i_x  in  N x W  per-channel beat data, packed [N-1:0][W-1:0]
- i_x_last  in  N  per-channel end-of-packet flag; ignored when PACKET=0
- o_x_rdy  out  N  per-channel accept; at most one bit set
- o_y_vld  out  1  output beat valid
- o_y  out  W  output beat data
- o_y_last  out  1  output end-of-packet flag (copy of the source's i_x_last; 0 when PACKET=0)
- o_y_sel  out  N  one-hot source channel of the current output beat
- i_y_rdy  in  1  sink accept

## Operation

- Transfer on any interface occurs when vld & rdy are both high at a rising edge.
- accept = !o_y_vld | i_y_rdy: the output register is empty or drains this cycle.
- Priority: one-hot pointer P; the highest-priority channel is P, then P+1, and so on, modulo N. Grant G is the first set bit of i_x_vld, searched cyclically from P. G is zero when no channel is valid.
- o_x_rdy = G & {N{accept}} when unlocked. o_x_rdy may depend combinationally on i_x_vld and i_y_rdy. A producer must not make vld depend on rdy.
- Data path: one-hot AND-OR select of i_x and i_x_last by G. It is loaded into o_y and o_y_last on transfer, and G is loaded into o_y_sel.
- Register update on a clock edge:
  - input transfer: o_y_vld = 1;
  - else if i_y_rdy: o_y_vld = 0;
  - else the register holds and o_y, o_y_last and o_y_sel are stable.
- Pointer update happens only on an input transfer from channel k. P becomes k+1 mod N. In PACKET=1 the pointer moves only when the transferred beat has last=1.
- Lock (PACKET=1 only):
  - A transfer from channel k with last=0 sets lock=1 and records k as the owner.
  - While locked, G = owner & i_x_vld[owner]. Other channels are never granted, even if the owner deasserts valid.
  - A transfer from the owner with last=1 clears the lock.
- N=1: G = i_x_vld[0]; the pointer is constant.

## Timing

- Reset (arst_n low, takes effect immediately):
  - o_y_vld=0, o_y=0, o_y_last=0, o_y_sel=0;
  - P selects channel 0; lock=0; o_x_rdy=0.
- Reset mid-packet or with a beat pending discards the beat and the lock. The first grant after reset uses channel-0 priority.
- Latency is 1 cycle: a beat accepted at edge t is presented on o_y/o_y_vld after edge t.
- Throughput is 1 beat per cycle with i_y_rdy held high.
- Back-pressure (o_y_vld=1, i_y_rdy=0): all o_x_rdy=0 and the output is held. No bubble is inserted when i_y_rdy returns, because a new beat loads in the same cycle the old one drains.
- Simultaneous requests from all channels with P=0 produce grants 0,1,…,N-1,0,… on consecutive transfers.
- A newly asserting channel is eligible in the same cycle. No request is starved longer than N-1 transfers (PACKET=0) or N-1 packets (PACKET=1).

## Test plan

- Reset: N=4, W=8. Hold arst_n=0 with all inputs valid and i_y_rdy=1 → o_y_vld=0, o_y=8'h00, o_y_sel=4'b0000, o_x_rdy=4'b0000. Release reset, then on the first cycle → o_x_rdy=4'b0001, and o_y=i_x[0] one cycle later.
- Round-robin: all four channels always valid with data 8'hA0+k, i_y_rdy=1 → output sequence A0,A1,A2,A3,A0 on consecutive cycles with o_y_sel walking one-hot 0001→0010→0100→1000→0001.
- Back-pressure: beat 8'h55 from channel 2 pending, i_y_rdy=0 for 3 cycles → o_y=8'h55 stable, o_x_rdy=0000 throughout. Raise i_y_rdy → 8'h55 transfers and the next grant loads in the same cycle.
- Fairness after a skip: only channels 1 and 3 valid, starting with P=0 → grants alternate 1,3,1,3. Channel 0 asserts valid after a grant to 3 → channel 0 is granted next.
- Packet lock (PACKET=1): channel 1 sends 3 beats (last on the third) while channel 0 is valid throughout, and channel 1 drops valid for 2 cycles between beats 1 and 2 → only channel 1 is granted until its last beat; channel 0 is granted the cycle after that transfer. No channel-0 grant occurs during the gap.
- Reset mid-packet: assert arst_n=0 while locked to channel 3 with o_y_vld=1 → o_y_vld=0 immediately. After release with channels 0 and 3 valid → channel 0 is granted first.
